// File: rtl/fmap_pingpong_loader_pkg.sv
// Shared constants and types for the ping-pong feature-map loader.
// Image geometry, pixel type and per-bank fill state.
package fmap_pingpong_loader_pkg;

    localparam int unsigned FMAP_IMG_W             = 29;
    localparam int unsigned FMAP_IMG_H             = 13;
    localparam int unsigned FEATURE_MAP_RESOLUTION = 8;
    localparam int unsigned FEATURE_MAP_ADDRWIDE   = 9;
    localparam int unsigned FMAP_TOTAL_PIXELS      = FMAP_IMG_W * FMAP_IMG_H;

    typedef logic signed [FEATURE_MAP_RESOLUTION-1:0] fmap_pixel_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } fmap_bank_state_e;

endpackage

// File: rtl/fmap_pingpong_loader_bank_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// Storage is not reset; only the read-data register is.
module fmap_bank_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/fmap_pingpong_loader.sv
// Ping-pong feature-map loader: fills one bank from the mqcRec stream while the CNN reads the other.
// Optional macro FMAP_SEQ_CHECK_EN adds a sticky sequential-address checker on seq_err_o.
module fmap_pingpong_loader #(
    parameter int unsigned REC_IMG_W = fmap_pingpong_loader_pkg::FMAP_IMG_W,
    parameter int unsigned REC_IMG_H = fmap_pingpong_loader_pkg::FMAP_IMG_H,
    parameter int unsigned DATA_W    = fmap_pingpong_loader_pkg::FEATURE_MAP_RESOLUTION,
    parameter int unsigned ADDR_W    = fmap_pingpong_loader_pkg::FEATURE_MAP_ADDRWIDE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mqcRec_valid_i,
    input  logic [DATA_W-1:0] mqcRec_data_i,
    input  logic [ADDR_W-1:0] mqcRec_addr_i,
    output logic              mqcRec_ready_o,
    output logic              fmap_valid_o,
    input  logic              fmap_rd_en_i,
    input  logic [ADDR_W-1:0] fmap_rd_addr_i,
    output logic [DATA_W-1:0] fmap_rd_data_o,
    input  logic              fmap_release_i,
    output logic              addr_err_o,
    output logic              seq_err_o
);

    import fmap_pingpong_loader_pkg::*;

    localparam int unsigned       TOTAL_PIXELS = REC_IMG_W * REC_IMG_H;
    localparam logic [ADDR_W:0]   TOTAL_L      = (ADDR_W+1)'(TOTAL_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_PIX     = ADDR_W'(TOTAL_PIXELS - 1);

    fmap_bank_state_e  bank_state [2];
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] pix_cnt;
    logic              addr_err_q;

    logic              beat_acc;
    logic              addr_ok;
    logic              wr_fire;
    logic              frame_done;
    logic              release_fire;

    assign mqcRec_ready_o = (bank_state[wr_bank] != BANK_FULL);
    assign fmap_valid_o   = (bank_state[rd_bank] == BANK_FULL);
    assign addr_err_o     = addr_err_q;

    assign beat_acc     = mqcRec_valid_i & mqcRec_ready_o;
    assign addr_ok      = ({1'b0, mqcRec_addr_i} < TOTAL_L);
    assign wr_fire      = beat_acc & addr_ok;
    assign frame_done   = wr_fire & (pix_cnt == LAST_PIX);
    assign release_fire = fmap_release_i & fmap_valid_o;

    // Completion hits wr_bank (never FULL while accepting) and release hits rd_bank (FULL),
    // so both may update in the same cycle without colliding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            pix_cnt       <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            if (beat_acc && !addr_ok) begin
                addr_err_q <= 1'b1;
            end
            if (wr_fire) begin
                if (frame_done) begin
                    bank_state[wr_bank] <= BANK_FULL;
                    wr_bank             <= ~wr_bank;
                    pix_cnt             <= '0;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                    if (bank_state[wr_bank] == BANK_EMPTY) begin
                        bank_state[wr_bank] <= BANK_FILLING;
                    end
                end
            end
            if (release_fire) begin
                bank_state[rd_bank] <= BANK_EMPTY;
                rd_bank             <= ~rd_bank;
            end
        end
    end

    logic [DATA_W-1:0] ram_rd [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fmap_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .wr_en_i   (wr_fire && (wr_bank == 1'(b))),
            .wr_addr_i (mqcRec_addr_i),
            .wr_data_i (mqcRec_data_i),
            .rd_en_i   (fmap_rd_en_i),
            .rd_addr_i (fmap_rd_addr_i),
            .rd_data_o (ram_rd[b])
        );
    end

    // Both banks are read every strobe; the bank and range decision is captured alongside
    // so the output mux lines up with the registered RAM data.
    logic rd_sel_q;
    logic rd_oob_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_sel_q <= 1'b0;
            rd_oob_q <= 1'b0;
        end else if (fmap_rd_en_i) begin
            rd_sel_q <= rd_bank;
            rd_oob_q <= !({1'b0, fmap_rd_addr_i} < TOTAL_L);
        end
    end

    assign fmap_rd_data_o = rd_oob_q ? '0 : (rd_sel_q ? ram_rd[1] : ram_rd[0]);

`ifdef FMAP_SEQ_CHECK_EN
    logic [ADDR_W-1:0] exp_addr;
    logic              seq_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_addr  <= '0;
            seq_err_q <= 1'b0;
        end else if (beat_acc) begin
            if (mqcRec_addr_i != exp_addr) begin
                seq_err_q <= 1'b1;
            end
            exp_addr <= frame_done ? '0 : exp_addr + 1'b1;
        end
    end

    assign seq_err_o = seq_err_q;
`else
    assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fmap_pingpong_loader.sv
// Randomized directed bench for fmap_pingpong_loader against a frame-queue reference model.
// Honours FMAP_SEQ_CHECK_EN the same way the design does.
module tb_fmap_pingpong_loader;

    localparam int TOTAL = 377;

`ifdef FMAP_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [8:0] addr_in = '0;
    logic       ready;
    logic       fvalid;
    logic       rd_en = 1'b0;
    logic [8:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rel = 1'b0;
    logic       addr_err;
    logic       seq_err;

    always #5 clk = ~clk;

    fmap_pingpong_loader dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .mqcRec_valid_i (valid_in),
        .mqcRec_data_i  (data_in),
        .mqcRec_addr_i  (addr_in),
        .mqcRec_ready_o (ready),
        .fmap_valid_o   (fvalid),
        .fmap_rd_en_i   (rd_en),
        .fmap_rd_addr_i (rd_addr),
        .fmap_rd_data_o (rd_data),
        .fmap_release_i (rel),
        .addr_err_o     (addr_err),
        .seq_err_o      (seq_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: completed frames queued oldest-first (TOTAL ints each, -1 = never written).
    int fq [$];
    int cur [TOTAL];
    int cnt;
    bit m_aerr;
    bit m_serr;
    int expv;
    int exp_rd;
    bit rd_known;
    bit last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        fq.delete();
        foreach (cur[i]) cur[i] = -1;
        cnt      = 0;
        m_aerr   = 1'b0;
        m_serr   = 1'b0;
        expv     = 0;
        exp_rd   = 0;
        rd_known = 1'b1;
    endfunction

    task automatic cycle();
        int  nf;
        bit  ready_m, valid_m, acc;
        int  a, ra;
        nf      = fq.size() / TOTAL;
        ready_m = (nf < 2);
        valid_m = (nf > 0);
        a       = int'(addr_in);
        ra      = int'(rd_addr);
        if (rd_en) begin
            if (ra >= TOTAL) begin
                exp_rd = 0; rd_known = 1'b1;
            end else if (valid_m && fq[ra] >= 0) begin
                exp_rd = fq[ra]; rd_known = 1'b1;
            end else begin
                rd_known = 1'b0;
            end
        end
        acc = valid_in && ready_m;
        if (acc) begin
            if (SEQ_ON && a != expv) m_serr = 1'b1;
            expv++;
            if (a >= TOTAL) m_aerr = 1'b1;
            else begin
                cur[a] = int'(data_in);
                cnt++;
            end
        end
        if (rel && valid_m) repeat (TOTAL) void'(fq.pop_front());
        if (acc && a < TOTAL && cnt == TOTAL) begin
            foreach (cur[i]) fq.push_back(cur[i]);
            foreach (cur[i]) cur[i] = -1;
            cnt  = 0;
            expv = 0;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        nf = fq.size() / TOTAL;
        check("ready",    {31'b0, ready},    {31'b0, nf < 2});
        check("valid",    {31'b0, fvalid},   {31'b0, nf > 0});
        check("addr_err", {31'b0, addr_err}, {31'b0, m_aerr});
        check("seq_err",  {31'b0, seq_err},  {31'b0, m_serr});
        if (rd_known) check("rd_data", {24'b0, rd_data}, exp_rd[31:0]);
    endtask

    task automatic send_beat(input int a, input int d);
        bit done = 1'b0;
        valid_in = 1'b1;
        addr_in  = a[8:0];
        data_in  = d[7:0];
        for (int k = 0; k < 20 && !done; k++) begin
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 9'($urandom_range(0, 511));
            cycle();
            done = last_acc;
        end
        if (!done) begin
            miscompares++;
            $error("FAIL beat_timeout: observed not accepted expected accepted");
        end
        valid_in = 1'b0;
        rd_en    = 1'b0;
        if ($urandom_range(0, 7) == 0) cycle();
    endtask

    task automatic read_at(input int a);
        rd_en   = 1'b1;
        rd_addr = a[8:0];
        cycle();
        rd_en   = 1'b0;
    endtask

    task automatic pulse_release();
        rel = 1'b1;
        cycle();
        rel = 1'b0;
    endtask

    task automatic apply_reset();
        valid_in = 1'b0;
        rd_en    = 1'b0;
        rel      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ready",    {31'b0, ready},    32'd1);
        check("rst_valid",    {31'b0, fvalid},   32'd0);
        check("rst_rd_data",  {24'b0, rd_data},  32'd0);
        check("rst_addr_err", {31'b0, addr_err}, 32'd0);
        check("rst_seq_err",  {31'b0, seq_err},  32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int frame_a_chk;
        model_reset();
        apply_reset();

        // Frame A: sequential addresses, data = addr[7:0].
        for (int i = 0; i < TOTAL; i++) send_beat(i, i & 255);
        read_at(0);
        check("frameA_0", {24'b0, rd_data}, 32'h00);
        read_at(100);
        check("frameA_100", {24'b0, rd_data}, 32'h64);
        read_at(376);
        check("frameA_376", {24'b0, rd_data}, 32'h78);
        read_at(500);
        check("rd_oob", {24'b0, rd_data}, 32'h00);

        // Frame B fills the other bank; then both banks are full and the producer stalls.
        for (int i = 0; i < TOTAL; i++) send_beat(i, int'($urandom_range(0, 255)));
        check("stall_ready", {31'b0, ready}, 32'd0);
        valid_in = 1'b1;
        addr_in  = 9'd0;
        data_in  = 8'h5a;
        repeat (4) begin
            cycle();
            check("stall_no_accept", {31'b0, last_acc}, 32'd0);
        end
        read_at(100);
        frame_a_chk = 100;
        check("still_frameA", {24'b0, rd_data}, frame_a_chk[31:0]);
        valid_in = 1'b1;
        rel = 1'b1;
        cycle();
        rel = 1'b0;
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) read_at(int'($urandom_range(0, 376)));

        // Frame C: random addresses with duplicates plus one out-of-range beat mid-frame.
        send_beat(0, 8'h5a);
        for (int i = 1; i < TOTAL; i++) begin
            if (i == 50) send_beat(400, 8'hee);
            send_beat(int'($urandom_range(0, 376)), int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 6; i++) read_at(int'($urandom_range(0, 376)));
        pulse_release();
        for (int i = 0; i < 6; i++) read_at(int'($urandom_range(0, 376)));
        pulse_release();
        pulse_release();
        cycle();

        // Frame D after a release that had nothing to release.
        for (int i = 0; i < TOTAL; i++) send_beat(i, int'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) read_at(int'($urandom_range(0, 376)));
        pulse_release();

        // Reset in the middle of a frame, then a clean frame.
        for (int i = 0; i < 200; i++) send_beat(i, int'($urandom_range(0, 255)));
        apply_reset();
        for (int i = 0; i < TOTAL; i++) send_beat(i, int'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) read_at(int'($urandom_range(0, 376)));
        pulse_release();

        // Address sequence 0,1,3,4,...: third beat is out of order.
        apply_reset();
        for (int i = 0; i < TOTAL; i++) begin
            send_beat((i < 2) ? i : (i + 1) % TOTAL, int'($urandom_range(0, 255)));
            if (i == 2) check("seq_err_third", {31'b0, seq_err}, {31'b0, SEQ_ON});
        end
        check("seq_frame_done", {31'b0, fvalid}, 32'd1);
        for (int i = 0; i < 4; i++) read_at(int'($urandom_range(0, 376)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
